fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 ireq_valid  output  1  instruction bus request valid.
REQ-005 ireq_addr  output  64  instruction bus request address (word-aligned).
REQ-006 iresp_addr_ok  input  1  bus accepted request this cycle.
REQ-007 iresp_data_ok  input  1  bus returns data for the oldest accepted request this cycle.
REQ-008 iresp_data  input  32  returned instruction word, valid with iresp_data_ok.
REQ-009 f_valid  output  1  fetched instruction presented to decode.
REQ-010 f_pc  output  64  PC of presented instruction.
REQ-011 f_raw_instr  output  32  raw instruction word for decode.
REQ-012 f_misalign  output  1  presented PC has pc[1:0]!=0; f_raw_instr is 32'h0000_0013.
REQ-013 d_ready  input  1  decode accepts the presented instruction this cycle.
REQ-014 redirect_valid  input  1  execute-stage control transfer (branch taken, jal, jalr).
REQ-015 redirect_pc  input  64  new fetch target, valid with redirect_valid.

Function
REQ-016 States: IDLE, REQ, WAIT, HOLD, FLUSH; at most one bus request outstanding.
REQ-017 IDLE -> REQ unconditionally; pc = RESET_PC.
REQ-018 REQ: ireq_valid=1, ireq_addr=pc; address SHALL stay stable until iresp_addr_ok.
REQ-019 REQ with pc[1:0]!=0: no bus request; go HOLD with f_misalign=1, f_raw_instr=32'h0000_0013.
REQ-020 REQ & iresp_addr_ok & no kill -> WAIT.
REQ-021 WAIT & iresp_data_ok -> HOLD; output register loads {pc, iresp_data}; f_valid=1 next cycle (request-to-output latency = bus latency + 1).
REQ-022 HOLD: f_valid, f_pc, f_raw_instr, f_misalign held stable until d_ready.
REQ-023 HOLD & d_ready & !redirect_valid -> REQ with pc = pc + 4 (64-bit, wraps modulo 2^64).
REQ-024 redirect_valid in HOLD (including with d_ready): instruction squashed, f_valid=0 next cycle, pc = redirect_pc, -> REQ.
REQ-025 redirect_valid in REQ without iresp_addr_ok: redirect_pc latched into pending target; request held; on later iresp_addr_ok -> FLUSH.
REQ-026 redirect_valid in REQ with iresp_addr_ok same cycle: pc = redirect_pc, -> FLUSH.
REQ-027 redirect_valid in WAIT without iresp_data_ok: pc = redirect_pc, -> FLUSH.
REQ-028 redirect_valid in WAIT with iresp_data_ok same cycle: data discarded, pc = redirect_pc, -> REQ.
REQ-029 FLUSH: ireq_valid=0; on iresp_data_ok data discarded, -> REQ with redirected pc.
REQ-030 Redirect in IDLE or REQ-before-accept with pc misaligned: pc = redirect_pc, -> REQ.
REQ-031 A later redirect_valid overrides any pending redirect target.
REQ-032 f_valid is never asserted in IDLE, REQ, WAIT or FLUSH.

Reset
REQ-033 While resetn=0: state=IDLE, pc=RESET_PC, ireq_valid=0, f_valid=0, f_misalign=0, f_pc=0, f_raw_instr=0, pending redirect cleared.
REQ-034 Reset asserted mid-transaction abandons the outstanding request; responses after reset release are assumed absent.

Structure
REQ-035 fetch_data_t {valid, pc, raw_instr, misalign} and NOP_INSTR = 32'h0000_0013 reside in pipes; RESET_PC default resides in common.
REQ-036 State enum is local to fetch_unit; no sub-module required.

Verification
REQ-037 Reset release, bus addr_ok immediate, data_ok after 2 cycles with 32'h00000513, d_ready=1 -> ireq_addr 8000_0000; f_valid 1 cycle after data_ok with f_pc 8000_0000; next request 8000_0004.
REQ-038 d_ready=0 for 5 cycles in HOLD -> f_* stable for 5 cycles, no new ireq_valid.
REQ-039 redirect_valid to 8000_0100 while in WAIT -> returned data dropped (f_valid stays 0), next ireq_addr 8000_0100.
REQ-040 redirect_valid and d_ready same cycle in HOLD -> f_valid 0 next cycle, next ireq_addr = redirect_pc.
REQ-041 redirect to 8000_0102 -> no bus request; f_valid=1, f_misalign=1, f_raw_instr 32'h0000_0013.
REQ-042 resetn pulsed low during WAIT -> outputs at reset values immediately; fetch restarts at 8000_0000.

Source files
------------

// File: rtl/common.sv
// Core-wide constants shared by the pipeline front end.
package common;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
endpackage

// File: rtl/pipes.sv
// Inter-stage payload types and constants for the pipeline.
package pipes;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        misalign;
  } fetch_data_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one bus request in flight, one-entry output register to decode,
// redirect handling that drains a stale in-flight request before refetching.
//
// state | meaning
// IDLE  | first cycle after reset, picks RESET_PC
// REQ   | bus request at pc (or misaligned pc turned into a NOP)
// WAIT  | request accepted, awaiting data
// HOLD  | instruction presented to decode until taken or squashed
// FLUSH | stale request in flight, data will be dropped
module fetch_unit
  import common::*;
  import pipes::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_raw_instr,
  output logic        f_misalign,
  input  logic        d_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic        pend_q, pend_d;
  logic        ireq_valid_q, ireq_valid_d;
  fetch_data_t fd_q, fd_d;
  logic        pc_mis;

  assign pc_mis = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    fd_d      = fd_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        pc_d    = redirect_valid ? redirect_pc : RESET_PC;
      end
      REQ: begin
        if (pc_mis) begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            state_d = HOLD;
            fd_d    = '{valid: 1'b1, pc: pc_q, raw_instr: NOP_INSTR, misalign: 1'b1};
          end
        end else if (iresp_addr_ok) begin
          pend_d = 1'b0;
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = FLUSH;
          end else if (pend_q) begin
            pc_d    = pend_pc_q;
            state_d = FLUSH;
          end else begin
            state_d = WAIT;
          end
        end else if (redirect_valid) begin
          // Bus address must not change until accepted, so park the new target.
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = iresp_data_ok ? REQ : FLUSH;
        end else if (iresp_data_ok) begin
          state_d = HOLD;
          fd_d    = '{valid: 1'b1, pc: pc_q, raw_instr: iresp_data, misalign: 1'b0};
        end
      end
      HOLD: begin
        if (redirect_valid || d_ready) begin
          pc_d          = redirect_valid ? redirect_pc : pc_q + 64'd4;
          state_d       = REQ;
          fd_d.valid    = 1'b0;
          fd_d.misalign = 1'b0;
        end
      end
      FLUSH: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (iresp_data_ok) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    ireq_valid_d = (state_d == REQ) && (pc_d[1:0] == 2'b00);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      ireq_valid_q <= 1'b0;
      fd_q         <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      ireq_valid_q <= ireq_valid_d;
      fd_q         <= fd_d;
    end
  end

  assign ireq_valid  = ireq_valid_q;
  assign ireq_addr   = pc_q;
  assign f_valid     = fd_q.valid;
  assign f_pc        = fd_q.pc;
  assign f_raw_instr = fd_q.raw_instr;
  assign f_misalign  = fd_q.misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: random bus/decode/redirect traffic against a program-order model
// (next presented pc = last redirect target, else retired pc + 4) plus directed scenarios.
module tb_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_raw_instr;
  logic        f_misalign;
  logic        d_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .f_valid(f_valid), .f_pc(f_pc), .f_raw_instr(f_raw_instr), .f_misalign(f_misalign),
    .d_ready(d_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus knobs
  int unsigned acc_pct = 100, lat_min = 0, lat_max = 0, rdy_pct = 100, redir_pct = 0;
  bit          dir_redir = 1'b0;
  logic [63:0] dir_pc = '0;

  // reference model / bus state
  logic [63:0] exp_pc = RESET_PC;
  bit          outstanding = 1'b0;
  bit          stale = 1'b0;
  logic [63:0] out_addr = '0;
  int          lat_cnt = 0;
  int          idle_cnt = 0;
  bit          prev_req_hold = 1'b0, prev_f_hold = 1'b0, prev_f_leave = 1'b0, prev_good_data = 1'b0;
  logic [63:0] prev_req_addr = '0, prev_f_pc = '0;
  logic [31:0] prev_f_raw = '0;
  logic        prev_f_mis = 1'b0;

  int unsigned cfg [4][5] = '{'{100, 0, 0, 100, 5}, '{50, 0, 3, 60, 8},
                              '{30, 1, 3, 30, 10}, '{80, 0, 1, 90, 3}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [63:0] a);
    if (a == RESET_PC) return 32'h0000_0513;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  function automatic logic [63:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 5)  return 64'hFFFF_FFFF_FFFF_FFF0 + (64'($urandom_range(0, 3)) << 2);
    if (r < 15) return RESET_PC + 64'($urandom_range(0, 1023));
    return RESET_PC + (64'($urandom_range(0, 255)) << 2);
  endfunction

  task automatic set_knobs(input int unsigned a, input int unsigned lmin, input int unsigned lmax,
                           input int unsigned r, input int unsigned rd);
    acc_pct = a; lat_min = lmin; lat_max = lmax; rdy_pct = r; redir_pct = rd;
  endtask

  task automatic step();
    logic rise, new_pres, mis;
    @(negedge clk);
    if (ireq_valid) begin
      check("req_aligned", 64'(ireq_addr[1:0]), 64'd0);
      check("req_one_outstanding", 64'(outstanding), 64'd0);
      check("req_not_with_fvalid", 64'(f_valid), 64'd0);
    end
    if (prev_req_hold) begin
      check("req_held_valid", 64'(ireq_valid), 64'd1);
      check("req_held_addr", ireq_addr, prev_req_addr);
    end
    rise = ireq_valid && !prev_req_hold;
    if (rise) check("req_addr", ireq_addr, exp_pc);
    if (prev_f_hold) begin
      check("hold_valid", 64'(f_valid), 64'd1);
      check("hold_pc", f_pc, prev_f_pc);
      check("hold_raw", 64'(f_raw_instr), 64'(prev_f_raw));
      check("hold_misalign", 64'(f_misalign), 64'(prev_f_mis));
    end
    if (prev_f_leave) check("f_valid_drop", 64'(f_valid), 64'd0);
    if (prev_good_data) check("f_latency", 64'(f_valid), 64'd1);
    new_pres = f_valid && !prev_f_hold;
    if (new_pres) begin
      mis = (exp_pc[1:0] != 2'b00);
      check("f_pc", f_pc, exp_pc);
      check("f_misalign", 64'(f_misalign), 64'(mis));
      check("f_raw_instr", 64'(f_raw_instr), 64'(mis ? NOP : mem(exp_pc)));
      if (!mis) check("f_from_bus", 64'(prev_good_data), 64'd1);
      idle_cnt = 0;
    end else begin
      idle_cnt++;
      if (idle_cnt >= 300) begin
        check("progress_timeout", 64'(idle_cnt), 64'd0);
        idle_cnt = 0;
      end
    end

    d_ready = ($urandom_range(0, 99) < rdy_pct);
    if (dir_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = dir_pc;
      dir_redir      = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(0, 99) < redir_pct);
      redirect_pc    = rand_target();
    end
    iresp_addr_ok = ireq_valid && !outstanding && ($urandom_range(0, 99) < acc_pct);
    iresp_data_ok = outstanding && (lat_cnt == 0);
    iresp_data    = iresp_data_ok ? mem(out_addr) : $urandom();

    if (redirect_valid && (ireq_valid || outstanding)) stale = 1'b1;
    prev_good_data = iresp_data_ok && !stale;
    if (iresp_data_ok) begin
      outstanding = 1'b0;
      stale       = 1'b0;
    end else if (outstanding) begin
      lat_cnt--;
    end
    if (iresp_addr_ok) begin
      outstanding = 1'b1;
      out_addr    = ireq_addr;
      lat_cnt     = int'($urandom_range(lat_min, lat_max));
    end
    prev_req_hold = ireq_valid && !iresp_addr_ok;
    prev_req_addr = ireq_addr;
    prev_f_hold   = f_valid && !d_ready && !redirect_valid;
    prev_f_leave  = f_valid && (d_ready || redirect_valid);
    prev_f_pc     = f_pc;
    prev_f_raw    = f_raw_instr;
    prev_f_mis    = f_misalign;
    if (redirect_valid)            exp_pc = redirect_pc;
    else if (f_valid && d_ready)   exp_pc = exp_pc + 64'd4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    d_ready = 1'b0; redirect_valid = 1'b0; iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
    #1;
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_f_valid", 64'(f_valid), 64'd0);
    check("rst_f_misalign", 64'(f_misalign), 64'd0);
    check("rst_f_pc", f_pc, 64'd0);
    check("rst_f_raw", 64'(f_raw_instr), 64'd0);
    outstanding = 1'b0; stale = 1'b0; idle_cnt = 0; exp_pc = RESET_PC;
    prev_req_hold = 1'b0; prev_f_hold = 1'b0; prev_f_leave = 1'b0; prev_good_data = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // what: 0 = bus request accepted/in flight, 1 = instruction presented
  task automatic wait_for(input int what, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      hit = (what == 0) ? outstanding : f_valid;
      if (hit) break;
    end
    check(tag, 64'(hit), 64'd1);
  endtask

  initial begin
    do_reset();

    // basic fetch: immediate accept, fixed latency, decode always ready
    set_knobs(100, 2, 2, 100, 0);
    repeat (14) step();

    // decode stalls 5 cycles while an instruction is held
    set_knobs(100, 1, 1, 0, 0);
    wait_for(1, "wait_present_stall");
    repeat (5) step();
    set_knobs(100, 1, 1, 100, 0);
    repeat (6) step();

    // redirect while waiting for data
    set_knobs(100, 3, 3, 100, 0);
    wait_for(0, "wait_inflight_redirect");
    dir_redir = 1'b1; dir_pc = 64'h8000_0100;
    repeat (14) step();

    // redirect coincident with decode accept
    set_knobs(100, 1, 1, 0, 0);
    wait_for(1, "wait_present_redirect");
    rdy_pct = 100; dir_redir = 1'b1; dir_pc = 64'h8000_0200;
    repeat (10) step();

    // misaligned target becomes a NOP without a bus request
    set_knobs(100, 1, 1, 0, 0);
    wait_for(1, "wait_present_misalign");
    dir_redir = 1'b1; dir_pc = 64'h8000_0102;
    repeat (4) step();
    rdy_pct = 100;
    repeat (4) step();
    dir_redir = 1'b1; dir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    repeat (14) step();

    // redirect while a request is waiting for acceptance
    set_knobs(0, 1, 1, 100, 0);
    repeat (2) step();
    dir_redir = 1'b1; dir_pc = 64'h8000_0040;
    repeat (2) step();
    acc_pct = 100;
    repeat (12) step();

    // reset in the middle of an outstanding request
    set_knobs(100, 3, 3, 100, 0);
    wait_for(0, "wait_inflight_reset");
    do_reset();
    repeat (12) step();

    for (int c = 0; c < 4; c++) begin
      set_knobs(cfg[c][0], cfg[c][1], cfg[c][2], cfg[c][3], cfg[c][4]);
      repeat (700) step();
      if (c == 1) begin
        wait_for(0, "wait_inflight_reset_rnd");
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
